// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared tag type, stage indices and match helper for the hazard unit
package pipe_pkg;

    localparam int TAG_AW = 5;
    localparam int FWD_RF = 0;
    localparam int ST_EX  = 1;
    localparam int ST_MEM = 2;
    localparam int ST_WB  = 3;

    typedef struct packed {
        logic              vld;
        logic [TAG_AW-1:0] rd;
        logic              wen;
        logic              ld;
    } tag_t;

    // x0 is hardwired zero, so a write to it can never feed a reader.
    function automatic logic tag_match(input tag_t t, input logic [TAG_AW-1:0] rs, input logic used);
        return t.vld && t.wen && (t.rd == rs) && (rs != '0) && used;
    endfunction

endpackage

// File: rtl/pipe_tag_stage.sv
// rtl/pipe_tag_stage.sv - one shadow destination-tag register with enable and clear
module pipe_tag_stage
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  tag_t d,
    output tag_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= clr ? '0 : d;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - load-use/branch stall, redirect flush and forwarding select for the in-order pipe
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW   = TAG_AW,
    parameter int DEPTH    = ST_WB,
    parameter int LOAD_RDY = ST_WB,
    parameter int ALU_RDY  = ST_MEM,
    parameter int CNT_W    = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         id_valid_i,
    input  logic [REG_AW-1:0]            id_rs1_i,
    input  logic [REG_AW-1:0]            id_rs2_i,
    input  logic                         id_rs1_used_i,
    input  logic                         id_rs2_used_i,
    input  logic [REG_AW-1:0]            id_rd_i,
    input  logic                         id_wen_i,
    input  logic                         id_load_i,
    input  logic                         id_branch_i,
    input  logic                         id_redirect_i,
    input  logic                         freeze_i,
    output logic                         pc_en_o,
    output logic                         ifid_en_o,
    output logic                         ifid_flush_o,
    output logic                         idex_bubble_o,
    output logic [$clog2(DEPTH+1)-1:0]   fwd1_sel_o,
    output logic [$clog2(DEPTH+1)-1:0]   fwd2_sel_o,
    output logic [CNT_W-1:0]             stall_cnt_o,
    output logic [CNT_W-1:0]             flush_cnt_o
);

    localparam int SEL_W = $clog2(DEPTH+1);

    tag_t             tag_q [ST_EX:DEPTH];
    tag_t             head_tag;
    logic             shift_en;
    logic             head_clr;
    logic             stall;
    logic             hz1, hz2;
    logic [SEL_W-1:0] sel1, sel2;
    logic             run;

    assign head_tag = tag_t'{vld: 1'b1, rd: TAG_AW'(id_rd_i), wen: id_wen_i, ld: id_load_i};
    assign shift_en = !freeze_i;
    assign head_clr = !(id_valid_i && !stall);

    for (genvar k = ST_EX; k <= DEPTH; k++) begin : g_stage
        if (k == ST_EX) begin : g_head
            pipe_tag_stage u_tag (
                .clk   (clk_i),
                .rst_n (rst_i),
                .en    (shift_en),
                .clr   (head_clr),
                .d     (head_tag),
                .q     (tag_q[k])
            );
        end else begin : g_body
            pipe_tag_stage u_tag (
                .clk   (clk_i),
                .rst_n (rst_i),
                .en    (shift_en),
                .clr   (1'b0),
                .d     (tag_q[k-1]),
                .q     (tag_q[k])
            );
        end
    end

    // Walk oldest to youngest so the youngest producer overwrites the select last.
    always_comb begin
        sel1 = SEL_W'(FWD_RF);
        sel2 = SEL_W'(FWD_RF);
        hz1  = 1'b0;
        hz2  = 1'b0;
        for (int k = DEPTH; k >= ST_EX; k--) begin
            if (id_valid_i && tag_match(tag_q[k], TAG_AW'(id_rs1_i), id_rs1_used_i)) begin
                sel1 = SEL_W'(k);
                hz1  = (tag_q[k].ld && k < LOAD_RDY) || (id_branch_i && k < ALU_RDY);
            end
            if (id_valid_i && tag_match(tag_q[k], TAG_AW'(id_rs2_i), id_rs2_used_i)) begin
                sel2 = SEL_W'(k);
                hz2  = (tag_q[k].ld && k < LOAD_RDY) || (id_branch_i && k < ALU_RDY);
            end
        end
    end

    assign stall = hz1 || hz2;
    assign run   = rst_i && !freeze_i;

    // Stall suppresses the redirect; the branch re-resolves once its operands are ready.
    assign pc_en_o       = run && !stall;
    assign ifid_en_o     = run && !stall;
    assign idex_bubble_o = run && stall;
    assign ifid_flush_o  = run && id_redirect_i && !stall;
    assign fwd1_sel_o    = rst_i ? sel1 : SEL_W'(FWD_RF);
    assign fwd2_sel_o    = rst_i ? sel2 : SEL_W'(FWD_RF);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else if (!freeze_i) begin
            if (stall && !(&stall_cnt_o)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (ifid_flush_o && !(&flush_cnt_o)) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - directed bench with a reference model of the hazard rules
module tb_pipe_hazard_unit;

    localparam int DEPTH    = 3;
    localparam int LOAD_RDY = 3;
    localparam int ALU_RDY  = 2;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic       id_wen = 1'b0, id_load = 1'b0, id_branch = 1'b0, id_redirect = 1'b0;
    logic       freeze = 1'b0;

    logic        pc_en, ifid_en, ifid_flush, idex_bubble;
    logic [1:0]  fwd1_sel, fwd2_sel;
    logic [15:0] stall_cnt, flush_cnt;
    logic        pc_en_n, ifid_en_n, ifid_flush_n, idex_bubble_n;
    logic [1:0]  fwd1_sel_n, fwd2_sel_n;
    logic [3:0]  stall_cnt_n, flush_cnt_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit u_dut (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .id_rd_i(id_rd), .id_wen_i(id_wen), .id_load_i(id_load),
        .id_branch_i(id_branch), .id_redirect_i(id_redirect), .freeze_i(freeze),
        .pc_en_o(pc_en), .ifid_en_o(ifid_en), .ifid_flush_o(ifid_flush),
        .idex_bubble_o(idex_bubble), .fwd1_sel_o(fwd1_sel), .fwd2_sel_o(fwd2_sel),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    // Narrow-counter copy so saturation is reachable in a few dozen cycles.
    pipe_hazard_unit #(.CNT_W(4)) u_dut_n (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .id_rd_i(id_rd), .id_wen_i(id_wen), .id_load_i(id_load),
        .id_branch_i(id_branch), .id_redirect_i(id_redirect), .freeze_i(freeze),
        .pc_en_o(pc_en_n), .ifid_en_o(ifid_en_n), .ifid_flush_o(ifid_flush_n),
        .idex_bubble_o(idex_bubble_n), .fwd1_sel_o(fwd1_sel_n), .fwd2_sel_o(fwd2_sel_n),
        .stall_cnt_o(stall_cnt_n), .flush_cnt_o(flush_cnt_n)
    );

    typedef struct {
        bit vld;
        int rd;
        bit wen;
        bit ld;
    } mtag_t;

    mtag_t mq [1:DEPTH];
    int    m_stall = 0;
    int    m_flush = 0;

    function automatic int youngest(int rs, bit used);
        if (!id_valid || !used || rs == 0) return 0;
        for (int k = 1; k <= DEPTH; k++)
            if (mq[k].vld && mq[k].wen && mq[k].rd == rs) return k;
        return 0;
    endfunction

    function automatic bit model_stall();
        int s [2];
        s[0] = youngest(int'(id_rs1), id_rs1_used);
        s[1] = youngest(int'(id_rs2), id_rs2_used);
        for (int i = 0; i < 2; i++)
            if (s[i] != 0 && ((mq[s[i]].ld && s[i] < LOAD_RDY) || (id_branch && s[i] < ALU_RDY)))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic int sat(int v, int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 1; k <= DEPTH; k++) mq[k] <= mtag_t'{vld: 1'b0, rd: 0, wen: 1'b0, ld: 1'b0};
            m_stall <= 0;
            m_flush <= 0;
        end else if (!freeze) begin
            for (int k = DEPTH; k > 1; k--) mq[k] <= mq[k-1];
            mq[1] <= (id_valid && !model_stall())
                     ? mtag_t'{vld: 1'b1, rd: int'(id_rd), wen: id_wen, ld: id_load}
                     : mtag_t'{vld: 1'b0, rd: 0, wen: 1'b0, ld: 1'b0};
            m_stall <= m_stall + int'(model_stall());
            m_flush <= m_flush + int'(id_redirect && !model_stall());
        end
    end

    initial begin
        bit run, st;
        int e1, e2;
        forever begin
            @(negedge clk);
            run = rst_i && !freeze;
            st  = model_stall();
            e1  = rst_i ? youngest(int'(id_rs1), id_rs1_used) : 0;
            e2  = rst_i ? youngest(int'(id_rs2), id_rs2_used) : 0;
            check("pc_en", pc_en, run && !st);
            check("ifid_en", ifid_en, run && !st);
            check("idex_bubble", idex_bubble, run && st);
            check("ifid_flush", ifid_flush, run && id_redirect && !st);
            check("fwd1_sel", fwd1_sel, e1);
            check("fwd2_sel", fwd2_sel, e2);
            check("stall_cnt", stall_cnt, sat(m_stall, 16));
            check("flush_cnt", flush_cnt, sat(m_flush, 16));
            check("stall_cnt_narrow", stall_cnt_n, sat(m_stall, 4));
            check("flush_cnt_narrow", flush_cnt_n, sat(m_flush, 4));
        end
    end

    task automatic id_set(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit wen, bit ld, bit br, bit rdr);
        id_valid    = v;
        id_rs1      = 5'(rs1);
        id_rs1_used = u1;
        id_rs2      = 5'(rs2);
        id_rs2_used = u2;
        id_rd       = 5'(rd);
        id_wen      = wen;
        id_load     = ld;
        id_branch   = br;
        id_redirect = rdr;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        repeat (3) begin
            cyc();
            nop();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        nop();
        repeat (2) @(posedge clk);
        #3;
        check("reset_pc_en", pc_en, 0);
        check("reset_stall_cnt", stall_cnt, 0);
        check("reset_fwd1", fwd1_sel, 0);
        cyc();
        rst_i = 1'b1;

        // forward from EX then MEM
        id_set(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        #2 check("t1_empty_pc_en", pc_en, 1);
        cyc(); id_set(1, 5, 1, 0, 1, 10, 1, 0, 0, 0);
        #2 check("t1_fwd1_ex", fwd1_sel, 1);
        check("t1_fwd2_x0", fwd2_sel, 0);
        check("t1_pc_en", pc_en, 1);
        cyc(); id_set(1, 5, 1, 0, 0, 11, 1, 0, 0, 0);
        #2 check("t1_fwd1_mem", fwd1_sel, 2);
        drain();

        // load-use: load must reach stage LOAD_RDY before it can feed ID
        cyc(); id_set(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
        cyc(); id_set(1, 6, 1, 1, 1, 7, 1, 0, 0, 0);
        #2 check("t2_bubble_ex", idex_bubble, 1);
        check("t2_pc_en", pc_en, 0);
        check("t2_cnt_before", stall_cnt, 0);
        cyc();
        #2 check("t2_bubble_mem", idex_bubble, 1);
        cyc();
        #2 check("t2_released", idex_bubble, 0);
        check("t2_fwd1_wb", fwd1_sel, 3);
        check("t2_stall_cnt", stall_cnt, 2);
        drain();

        // branch operand from EX: stall, then redirect flush
        cyc(); id_set(1, 0, 0, 0, 0, 8, 1, 0, 0, 0);
        cyc(); id_set(1, 8, 1, 0, 1, 0, 0, 0, 1, 1);
        #2 check("t3_br_stall", idex_bubble, 1);
        check("t3_no_flush", ifid_flush, 0);
        cyc();
        #2 check("t3_flush", ifid_flush, 1);
        check("t3_no_bubble", idex_bubble, 0);
        cyc(); nop();
        #2 check("t3_flush_cnt", flush_cnt, 1);
        check("t3_stall_cnt", stall_cnt, 3);
        drain();

        // youngest producer wins, x0 never forwards
        cyc(); id_set(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        cyc(); id_set(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        cyc(); id_set(1, 9, 1, 9, 1, 0, 0, 0, 0, 0);
        #2 check("t4_fwd1_young", fwd1_sel, 1);
        check("t4_fwd2_young", fwd2_sel, 1);
        cyc(); id_set(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(); id_set(1, 0, 1, 9, 1, 0, 0, 0, 0, 0);
        #2 check("t4_fwd1_x0", fwd1_sel, 0);
        check("t4_fwd2_wb", fwd2_sel, 3);
        drain();

        // freeze during a load-use stall
        cyc(); id_set(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
        cyc(); id_set(1, 6, 1, 0, 0, 7, 1, 0, 0, 0);
        #2 check("t5_stall", idex_bubble, 1);
        check("t5_cnt", stall_cnt, 3);
        cyc(); freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            #2 check("t5_frz_pc_en", pc_en, 0);
            check("t5_frz_bubble", idex_bubble, 0);
            check("t5_frz_fwd1", fwd1_sel, 2);
            check("t5_frz_cnt", stall_cnt, 4);
        end
        cyc(); freeze = 1'b0;
        #2 check("t5_resume_stall", idex_bubble, 1);
        check("t5_resume_cnt", stall_cnt, 4);
        cyc();
        #2 check("t5_done_fwd1", fwd1_sel, 3);
        check("t5_done_cnt", stall_cnt, 5);
        drain();

        // async reset in the middle of a stall
        cyc(); id_set(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
        cyc(); id_set(1, 6, 1, 0, 0, 7, 1, 0, 0, 0);
        #2 check("t6_stall", idex_bubble, 1);
        rst_i = 1'b0;
        #1 check("t6_rst_cnt", stall_cnt, 0);
        check("t6_rst_pc_en", pc_en, 0);
        check("t6_rst_fwd1", fwd1_sel, 0);
        check("t6_rst_bubble", idex_bubble, 0);
        cyc();
        cyc(); rst_i = 1'b1;
        #2 check("t6_after_pc_en", pc_en, 1);
        check("t6_after_bubble", idex_bubble, 0);
        check("t6_after_flush_cnt", flush_cnt, 0);
        drain();

        // counter saturation on the narrow instance
        for (int n = 0; n < 8; n++) begin
            cyc(); id_set(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
            cyc(); id_set(1, 6, 1, 0, 0, 7, 1, 0, 0, 0);
            cyc();
            cyc();
        end
        drain();
        #2 check("t7_stall_wide", stall_cnt, 16);
        check("t7_stall_sat", stall_cnt_n, 15);
        for (int n = 0; n < 20; n++) begin
            cyc(); id_set(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        end
        cyc(); nop();
        #2 check("t7_flush_wide", flush_cnt, 20);
        check("t7_flush_sat", flush_cnt_n, 15);

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
